// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs and stall/flush/PC-select outputs of the hazard controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs, id_rt, ex_aw, mem_aw, wb_aw;
  logic id_use_rs, id_use_rt, ex_we, mem_we, wb_we;
  logic redirect_mem, halt_ex, irq, irq_en;
  logic [1:0] pc_sel, state;
  logic pause_IF, flush_id, flush_ex, flush_mem, irq_ack, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_rs, id_rt, ex_aw, mem_aw, wb_aw, id_use_rs, id_use_rt, ex_we, mem_we, wb_we,
           redirect_mem, halt_ex, irq, irq_en,
    input  pc_sel, state, pause_IF, flush_id, flush_ex, flush_mem, irq_ack, halted, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs, id_rt, ex_aw, mem_aw, wb_aw, id_use_rs, id_use_rt, ex_we, mem_we, wb_we,
           redirect_mem, halt_ex, irq, irq_en,
    output pc_sel, state, pause_IF, flush_id, flush_ex, flush_mem, irq_ack, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW stall, MEM redirect, irq/halt drain sequencing with saturating statistics
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int DRAIN = 3
) (
  input logic clk,
  input logic rst_ID,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int CW = DRAIN > 1 ? $clog2(DRAIN) : 1;
  typedef enum logic [1:0] {RUN, IRQ_DRAIN, HALT_DRAIN, HALTED} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic [1:0] pc_sel;
  logic pause, f_id, f_ex, f_mem, ack, stall_inc, flush_inc, halted_q;
  logic rs_hit, rt_hit, hazard;
  assign rs_hit = bus.id_use_rs && bus.id_rs != 5'd0 &&
                  ((bus.ex_we && bus.ex_aw == bus.id_rs) ||
                   (bus.mem_we && bus.mem_aw == bus.id_rs) ||
                   (bus.wb_we && bus.wb_aw == bus.id_rs));
  assign rt_hit = bus.id_use_rt && bus.id_rt != 5'd0 &&
                  ((bus.ex_we && bus.ex_aw == bus.id_rt) ||
                   (bus.mem_we && bus.mem_aw == bus.id_rt) ||
                   (bus.wb_we && bus.wb_aw == bus.id_rt));
  assign hazard = rs_hit || rt_hit;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    pc_sel = 2'd0;
    pause = 1'b0;
    f_id = 1'b0;
    f_ex = 1'b0;
    f_mem = 1'b0;
    ack = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (st)
      RUN:
        if (bus.redirect_mem) begin
          {pc_sel, f_id, f_ex, f_mem, flush_inc} = {2'd1, 4'b1111};
        end else if (bus.halt_ex || (bus.irq && bus.irq_en)) begin
          {pc_sel, pause, f_ex} = {2'd3, 2'b11};
          st_n = bus.halt_ex ? HALT_DRAIN : IRQ_DRAIN;
          cnt_n = CW'(DRAIN - 1);
        end else if (hazard) begin
          {pc_sel, pause, f_ex, stall_inc} = {2'd3, 3'b111};
        end
      IRQ_DRAIN:
        if (cnt == '0) begin
          {pc_sel, ack, f_id} = {2'd2, 2'b11};
          st_n = RUN;
        end else begin
          cnt_n = cnt - CW'(1);
          if (bus.redirect_mem) {pc_sel, f_id, f_ex, f_mem, flush_inc} = {2'd1, 4'b1111};
          else {pc_sel, pause, f_ex} = {2'd3, 2'b11};
        end
      HALT_DRAIN: begin
        {pc_sel, pause, f_ex} = {2'd3, 2'b11};
        st_n = cnt == '0 ? HALTED : HALT_DRAIN;
        cnt_n = cnt == '0 ? cnt : cnt - CW'(1);
      end
      HALTED: {pc_sel, pause, f_ex} = {2'd3, 2'b11};
    endcase
  end
  always_ff @(posedge clk or posedge rst_ID)
    if (rst_ID) begin
      st <= RUN;
      cnt <= '0;
      stall_q <= '0;
      flush_q <= '0;
      halted_q <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      stall_q <= stall_q + CNT_W'(stall_inc && stall_q != '1);
      flush_q <= flush_q + CNT_W'(flush_inc && flush_q != '1);
      halted_q <= st_n == HALTED;
    end
  assign bus.pc_sel = pc_sel;
  assign bus.pause_IF = pause;
  assign bus.flush_id = f_id;
  assign bus.flush_ex = f_ex;
  assign bus.flush_mem = f_mem;
  assign bus.irq_ack = ack;
  assign bus.halted = halted_q;
  assign bus.state = st;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for the hazard controller (CNT_W=4 to reach saturation)
module tb_pipeline_hazard_ctrl;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_ID;
  int checks = 0, errors = 0;
  logic [CW-1:0] esc = '0, efc = '0;
  typedef struct {
    logic [1:0] pc, st;
    logic pa, fi, fe, fm, ak, hl;
    logic [CW-1:0] sc, fc;
  } exp_t;
  exp_t q[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus();
  pipeline_hazard_ctrl #(.CNT_W(CW), .DRAIN(3)) dut (.clk(clk), .rst_ID(rst_ID), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [1:0] pc, logic pa, logic fi, logic fe, logic fm, logic ak, logic hl, logic [1:0] st);
    exp_t e;
    e.pc = pc; e.pa = pa; e.fi = fi; e.fe = fe; e.fm = fm; e.ak = ak; e.hl = hl; e.st = st;
    e.sc = '0; e.fc = '0;
    return e;
  endfunction
  function automatic exp_t idle();        return mk(2'd0, 0, 0, 0, 0, 0, 0, 2'd0); endfunction
  function automatic exp_t hold(logic [1:0] s); return mk(2'd3, 1, 0, 1, 0, 0, 0, s); endfunction
  function automatic exp_t redir(logic [1:0] s); return mk(2'd1, 0, 1, 1, 1, 0, 0, s); endfunction
  function automatic exp_t take();        return mk(2'd2, 0, 1, 0, 0, 1, 0, 2'd1); endfunction
  function automatic exp_t stopped();     return mk(2'd3, 1, 0, 1, 0, 0, 1, 2'd3); endfunction

  task automatic chk1(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic compare();
    exp_t x;
    if (q.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard: observed empty queue expected entry");
      return;
    end
    x = q.pop_front();
    chk1("pc_sel", 16'(bus.pc_sel), 16'(x.pc));
    chk1("pause_IF", 16'(bus.pause_IF), 16'(x.pa));
    chk1("flush_id", 16'(bus.flush_id), 16'(x.fi));
    chk1("flush_ex", 16'(bus.flush_ex), 16'(x.fe));
    chk1("flush_mem", 16'(bus.flush_mem), 16'(x.fm));
    chk1("irq_ack", 16'(bus.irq_ack), 16'(x.ak));
    chk1("halted", 16'(bus.halted), 16'(x.hl));
    chk1("state", 16'(bus.state), 16'(x.st));
    chk1("stall_cnt", 16'(bus.stall_cnt), 16'(x.sc));
    chk1("flush_cnt", 16'(bus.flush_cnt), 16'(x.fc));
  endtask

  task automatic cyc(input exp_t e, input bit si = 0, input bit fi = 0);
    e.sc = esc; e.fc = efc;
    q.push_back(e);
    if (si && esc != '1) esc = esc + 1'b1;
    if (fi && efc != '1) efc = efc + 1'b1;
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {bus.id_rs, bus.id_rt, bus.ex_aw, bus.mem_aw, bus.wb_aw} = '0;
    {bus.id_use_rs, bus.id_use_rt, bus.ex_we, bus.mem_we, bus.wb_we} = '0;
    {bus.redirect_mem, bus.halt_ex, bus.irq, bus.irq_en} = '0;
  endtask

  task automatic pulse_reset();
    rst_ID = 1'b1; esc = '0; efc = '0; clr();
    cyc(idle());
    rst_ID = 1'b0;
    cyc(idle());
  endtask

  initial begin
    rst_ID = 1'b1;
    clr();
    #1;
    cyc(idle());
    cyc(idle());
    rst_ID = 1'b0;
    cyc(idle());
    // RAW hazards against EX, MEM (rt) and WB, and the r0 exemption
    bus.ex_aw = 5; bus.ex_we = 1; bus.id_rs = 5; bus.id_use_rs = 1;
    cyc(hold(0), 1);
    bus.id_rs = 0; bus.ex_aw = 0;
    cyc(idle());
    clr(); bus.mem_aw = 7; bus.mem_we = 1; bus.id_rt = 7; bus.id_use_rt = 1;
    cyc(hold(0), 1);
    bus.id_use_rt = 0;
    cyc(idle());
    clr(); bus.wb_aw = 9; bus.wb_we = 1; bus.id_rs = 9; bus.id_use_rs = 1;
    cyc(hold(0), 1);
    bus.wb_we = 0;
    cyc(idle());
    // redirect wins over hazard, halt and irq
    clr(); bus.ex_aw = 3; bus.ex_we = 1; bus.id_rs = 3; bus.id_use_rs = 1;
    bus.halt_ex = 1; bus.irq = 1; bus.irq_en = 1; bus.redirect_mem = 1;
    cyc(redir(0), 0, 1);
    clr();
    cyc(idle());
    bus.irq = 1;
    cyc(idle());
    // interrupt drain: irq dropping mid-drain does not abort
    bus.irq_en = 1;
    cyc(hold(0));
    clr();
    cyc(hold(1));
    cyc(hold(1));
    cyc(take());
    cyc(idle());
    // interrupt drain with an older branch redirecting in the first drain cycle
    bus.irq = 1; bus.irq_en = 1;
    cyc(hold(0));
    clr(); bus.redirect_mem = 1;
    cyc(redir(1), 0, 1);
    bus.redirect_mem = 0;
    cyc(hold(1));
    cyc(take());
    cyc(idle());
    // halt drain ignores redirect and irq, then HALTED ignores everything
    bus.halt_ex = 1;
    cyc(hold(0));
    clr(); bus.redirect_mem = 1;
    cyc(hold(2));
    clr(); bus.irq = 1; bus.irq_en = 1;
    cyc(hold(2));
    cyc(hold(2));
    cyc(stopped());
    bus.redirect_mem = 1; bus.halt_ex = 1; bus.ex_aw = 4; bus.ex_we = 1; bus.id_rs = 4; bus.id_use_rs = 1;
    cyc(stopped());
    pulse_reset();
    // reset in the middle of an interrupt drain
    bus.irq = 1; bus.irq_en = 1;
    cyc(hold(0));
    cyc(hold(1));
    pulse_reset();
    // stall counter saturation at 15
    bus.ex_aw = 6; bus.ex_we = 1; bus.id_rt = 6; bus.id_use_rt = 1;
    for (int i = 0; i < 20; i++) cyc(hold(0), 1);
    clr();
    cyc(idle());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
